int_logic_dispatch: RTL and testbench

//  Upstream issue stage for the integer logic unit. Buffers logic ops (A, B, op code, tag) in a small FIFO.

---
 rtl/int_logic_dispatch_pkg.sv | 32 +++
 rtl/int_logic_dispatch_fifo.sv | 60 ++++++
 rtl/int_logic_dispatch.sv | 145 ++++++++++++++
 tb/tb_int_logic_dispatch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_logic_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// int_pkg : shared types for the integer logic dispatch stage
// Revision: 1.0
// ============================================================================
package int_pkg;

    localparam int INT_DATA_W = 32;
    localparam int INT_TAG_W  = 4;

    typedef enum logic [1:0] {
        LOGIC_OR  = 2'd0,
        LOGIC_AND = 2'd1,
        LOGIC_SLT = 2'd2,
        LOGIC_NOP = 2'd3
    } logic_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic [INT_DATA_W-1:0] a;
        logic [INT_DATA_W-1:0] b;
        logic_op_e             ctrl;
        logic [INT_TAG_W-1:0]  tag;
    } logic_req_t;

endpackage
`default_nettype wire

// File: rtl/int_logic_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// int_logic_fifo : synchronous FIFO of logic_req_t, head is read combinationally
// Revision: 1.0
// ============================================================================
module int_logic_fifo
    import int_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic_req_t             i_data,
    input  logic                   i_pop,
    output logic_req_t             o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PONE = AW'(1);

    logic_req_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PONE;
            if (w_push && !w_pop)      r_count <= r_count + C_ONE;
            else if (!w_push && w_pop) r_count <= r_count - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/int_logic_dispatch.sv
`default_nettype none
// ============================================================================
// int_logic_dispatch : buffers logic ops, issues them to the logic unit one at
// a time and returns tagged results on a valid/ready port.  Revision: 1.0
// ============================================================================
module int_logic_dispatch
    import int_pkg::*;
#(
    parameter int DATA_W  = INT_DATA_W,
    parameter int TAG_W   = INT_TAG_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              eu_ce,
    output logic [DATA_W-1:0] eu_a,
    output logic [DATA_W-1:0] eu_b,
    output logic [1:0]        eu_ctrl,
    input  logic              eu_ready,
    input  logic [DATA_W-1:0] eu_dout,
    input  logic              eu_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] C_TMO_ONE  = TW'(1);

    disp_state_e       r_state;
    logic [TW-1:0]     r_tmo;
    logic [TAG_W-1:0]  r_tag;
    logic_req_t        w_push_data;
    logic_req_t        w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;

    assign w_push_data.a    = in_a;
    assign w_push_data.b    = in_b;
    assign w_push_data.ctrl = logic_op_e'(in_ctrl);
    assign w_push_data.tag  = in_tag;

    assign w_push  = in_valid && in_ready;
    assign w_pop   = (r_state == ISSUE);
    assign w_issue = (r_state == IDLE) && !w_empty && eu_ready && (!out_valid || out_ready);

    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_pop)      w_count_next = w_count + C_ONE;
        else if (!w_push && w_pop) w_count_next = w_count - C_ONE;
    end

    int_logic_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // in_ready is registered from the next count so it reads 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tmo     <= '0;
            r_tag     <= '0;
            in_ready  <= 1'b0;
            eu_ce     <= 1'b0;
            eu_a      <= '0;
            eu_b      <= '0;
            eu_ctrl   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else begin
            in_ready <= (w_count_next != C_FULL);
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        eu_ce   <= 1'b1;
                        eu_a    <= w_head.a;
                        eu_b    <= w_head.b;
                        eu_ctrl <= w_head.ctrl;
                        r_tag   <= w_head.tag;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    eu_ce   <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (eu_done) begin
                        out_data  <= eu_dout;
                        out_tag   <= r_tag;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_tmo == C_TMO_LAST) begin
                        out_data  <= '0;
                        out_tag   <= r_tag;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + C_TMO_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_int_logic_dispatch.sv
`default_nettype none
// ============================================================================
// tb_int_logic_dispatch : directed stimulus, scoreboard queue and output monitor
// Revision: 1.0
// ============================================================================
module tb_int_logic_dispatch;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_ctrl = '0;
    logic [3:0]  in_tag = '0;
    logic        eu_ce;
    logic [31:0] eu_a;
    logic [31:0] eu_b;
    logic [1:0]  eu_ctrl;
    logic        eu_ready = 1'b1;
    logic [31:0] eu_dout = '0;
    logic        eu_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_err;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          results = 0;
    bit          hang = 1'b0;
    bit          saw_full = 1'b0;

    int_logic_dispatch #(.DATA_W(32), .TAG_W(4), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_ctrl(in_ctrl), .in_tag(in_tag),
        .eu_ce(eu_ce), .eu_a(eu_a), .eu_b(eu_b), .eu_ctrl(eu_ctrl),
        .eu_ready(eu_ready), .eu_dout(eu_dout), .eu_done(eu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Logic unit model: done one cycle after CE unless hung.
    always @(posedge clk) begin
        if (eu_ce && !hang) begin
            eu_done <= 1'b1;
            case (eu_ctrl)
                2'd0:    eu_dout <= eu_a | eu_b;
                2'd1:    eu_dout <= eu_a & eu_b;
                2'd2:    eu_dout <= {31'd0, (eu_a < eu_b)};
                default: eu_dout <= 32'd0;
            endcase
        end else begin
            eu_done <= 1'b0;
            eu_dout <= 32'd0;
        end
    end

    always @(negedge clk) if (rst_n && in_valid && !in_ready) saw_full = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    // Monitor: compare on every handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            results++;
            if (sb.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
                chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            end
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                           input logic [3:0] t, input logic [31:0] ed, input logic ee,
                           input bit track);
        int n;
        exp_t e;
        in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = c; in_tag = t;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin fail_now("push_wait"); break; end
        end
        @(posedge clk);
        if (track) begin
            e.data = ed; e.tag = t; e.err = ee;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_ce(output int c);
        int n;
        n = 0; c = -1;
        forever begin
            @(negedge clk);
            if (eu_ce) begin c = cyc; break; end
            n++;
            if (n > 100) begin fail_now("wait_eu_ce"); break; end
        end
    endtask

    task automatic wait_ov(output int c);
        int n;
        n = 0; c = -1;
        forever begin
            @(negedge clk);
            if (out_valid) begin c = cyc; break; end
            n++;
            if (n > 100) begin fail_now("wait_out_valid"); break; end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin fail_now("drain"); sb.delete(); break; end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p, c, v;
        logic [31:0] held_d;
        logic [3:0]  held_t;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_eu_ce", {31'd0, eu_ce}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 1: single op, latency
        push_op(32'hF0F0_0000, 32'h0FF0_00FF, 2'd0, 4'd3, 32'hFFF0_00FF, 1'b0, 1'b1);
        p = cyc;
        wait_ce(c);
        chk("t1_ce_cycle", c, p + 1);
        wait_ov(v);
        chk("t1_ov_cycle", v, p + 3);
        drain();

        // 2: burst of 6
        @(posedge clk); #1;
        saw_full = 1'b0;
        push_op(32'hFF00_FF00, 32'h0F0F_0F0F, 2'd1, 4'd0, 32'h0F00_0F00, 1'b0, 1'b1);
        push_op(32'h1234_0000, 32'h0000_5678, 2'd0, 4'd1, 32'h1234_5678, 1'b0, 1'b1);
        push_op(32'd5,         32'd7,         2'd2, 4'd2, 32'd1,         1'b0, 1'b1);
        push_op(32'd7,         32'd5,         2'd2, 4'd3, 32'd0,         1'b0, 1'b1);
        push_op(32'hFFFF_FFFF, 32'hA5A5_A5A5, 2'd1, 4'd4, 32'hA5A5_A5A5, 1'b0, 1'b1);
        push_op(32'h8000_0000, 32'h0000_0001, 2'd0, 4'd5, 32'h8000_0001, 1'b0, 1'b1);
        chk("t2_in_ready_dropped", {31'd0, saw_full}, 32'd1);
        drain();

        // 3: back-pressure holds one result
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_op(32'h0000_0011, 32'h0000_0100, 2'd0, 4'd8,  32'h0000_0111, 1'b0, 1'b1);
        push_op(32'h0000_FFFF, 32'h0000_0F0F, 2'd1, 4'd9,  32'h0000_0F0F, 1'b0, 1'b1);
        push_op(32'd1,         32'd2,         2'd2, 4'd10, 32'd1,         1'b0, 1'b1);
        wait_ov(v);
        held_d = out_data;
        held_t = out_tag;
        chk("t3_held_data", held_d, 32'h0000_0111);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data", out_data, held_d);
            chk("t3_hold_tag", {28'd0, out_tag}, {28'd0, held_t});
            chk("t3_no_issue", {31'd0, eu_ce}, 32'd0);
        end
        out_ready = 1'b1;
        drain();

        // 4: unit never completes -> error completion after 15 WAIT cycles
        @(posedge clk); #1;
        hang = 1'b1;
        push_op(32'h1111_1111, 32'h2222_2222, 2'd0, 4'd7, 32'd0, 1'b1, 1'b1);
        wait_ce(c);
        wait_ov(v);
        chk("t4_timeout_cycle", v, c + 16);
        drain();
        hang = 1'b0;
        @(posedge clk); #1;
        push_op(32'h0000_00F0, 32'h0000_000F, 2'd0, 4'd6, 32'h0000_00FF, 1'b0, 1'b1);
        drain();

        // 5: reset mid-WAIT with 2 queued
        @(posedge clk); #1;
        hang = 1'b1;
        push_op(32'd1, 32'd1, 2'd0, 4'd1, 32'd1, 1'b0, 1'b0);
        push_op(32'd2, 32'd2, 2'd0, 4'd2, 32'd2, 1'b0, 1'b0);
        push_op(32'd3, 32'd3, 2'd0, 4'd3, 32'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        p = results;
        rst_n = 1'b0;
        #1;
        chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_eu_ce", {31'd0, eu_ce}, 32'd0);
        chk("t5_eu_a", eu_a, 32'd0);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_out_data", out_data, 32'd0);
        chk("t5_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_stale", results, p);
        chk("t5_idle_valid", {31'd0, out_valid}, 32'd0);

        // 6: NOP with all-ones operands
        @(posedge clk); #1;
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 4'd12, 32'd0, 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
